regfile_wr_arbiter: RTL and testbench

// Shares the register file's single write port among NUM_REQ writeback sources
// (e.g. ALU, load unit, multiply/divide) using round-robin arbitration.

---
 rtl/regfile_wr_arbiter_pkg.sv | 13 +
 rtl/regfile_wr_arbiter_if.sv | 32 +++
 rtl/regfile_wr_arbiter_rr_arbiter.sv | 32 +++
 rtl/regfile_wr_arbiter.sv | 67 ++++++
 tb/tb_regfile_wr_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared register-file constants and small helpers for the writeback arbiter.
// The r0 address is defined here so every write-port client filters it consistently.
package regfile_wr_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Writeback bus: requester valid/ready/addr/data plus the register-file write port.
// master = requesters + register file side, slave = the arbiter.
interface regfile_wr_arbiter_if
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = REG_DATA_W,
  parameter int ADDR_W  = REG_ADDR_W
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic                      hold;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic [ID_W-1:0]           grant_id;

  modport master (
    output hold, req_valid, req_addr, req_data,
    input  req_ready, wr_en, wr_addr, wr_data, grant_id
  );

  modport slave (
    input  hold, req_valid, req_addr, req_data,
    output req_ready, wr_en, wr_addr, wr_data, grant_id
  );

endinterface

// File: rtl/regfile_wr_arbiter_rr_arbiter.sv
// Generic round-robin picker: first set request at or after ptr, wrapping.
// Purely combinational so it can be reused for the memory port.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin share of the register-file write port among NUM_REQ writeback sources.
// Holds the rotation pointer, the one-cycle write register and the r0 filter.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = REG_DATA_W,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input logic                  clk,
  input logic                  rst,
  regfile_wr_arbiter_if.slave  bus
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    win_idx;
  logic [NUM_REQ-1:0] win_grant;
  logic               win_any;
  logic               accept;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  // The output register drains every cycle, so readiness ignores the wr_* stage.
  assign accept        = win_any && !bus.hold && !rst;
  assign bus.req_ready = accept ? win_grant : '0;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == ID_W'(i)) begin
        sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      bus.grant_id <= '0;
      rr_ptr       <= '0;
    end else if (accept) begin
      // r0 writes complete the handshake but never reach the register file.
      bus.wr_en    <= (sel_addr != ADDR_W'(REG_ZERO));
      bus.wr_addr  <= sel_addr;
      bus.wr_data  <= sel_data;
      bus.grant_id <= win_idx;
      rr_ptr       <= ID_W'(wrap_inc(32'(win_idx), NUM_REQ));
    end else begin
      bus.wr_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios plus a random
// scoreboard against a queue-free behavioural model of the round-robin rules.
module tb_regfile_wr_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int IW = $clog2(N);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Register file: captures on negedge; cleared whenever the arbiter is in reset.
  logic [DW-1:0] rf [32];
  always @(negedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) rf[r] <= '0;
    end else if (bus.wr_en) begin
      rf[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Requesters must hold addr/data steady while stalled.
  logic [N-1:0]    stall_q;
  logic [N*AW-1:0] addr_q;
  logic [N*DW-1:0] data_q;
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (stall_q[i] && bus.req_valid[i])
          assert (bus.req_addr[i*AW +: AW] == addr_q[i*AW +: AW] &&
                  bus.req_data[i*DW +: DW] == data_q[i*DW +: DW])
          else $error("requester %0d changed addr/data while stalled", i);
      end
    end
    stall_q <= rst ? '0 : (bus.req_valid & ~bus.req_ready);
    addr_q  <= bus.req_addr;
    data_q  <= bus.req_data;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    bus.req_valid[i]         = v;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset;
    rst           = 1'b1;
    bus.hold      = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    rst = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1), DW'(32'h100 + i));
    #1;
    checks++;
    if (bus.req_ready !== 3'b000) begin
      errors++; $display("FAIL rst_ready got %b exp 000", bus.req_ready);
    end
    checks++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.grant_id} !== '0) begin
      errors++;
      $display("FAIL rst_state got en=%b a=%0d d=%h g=%0d exp all zero",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.grant_id);
    end
    tick;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 3'b001) begin
      errors++; $display("FAIL post_rst_ready got %b exp 001", bus.req_ready);
    end
    tick;
    tick;
    checks++;
    if (bus.wr_en !== 1'b1 || bus.grant_id !== 2'd1) begin
      errors++; $display("FAIL pre_midrst got en=%b g=%0d exp en=1 g=1", bus.wr_en, bus.grant_id);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.wr_en !== 1'b0 || bus.req_ready !== 3'b000) begin
      errors++; $display("FAIL midrst got en=%b rdy=%b exp en=0 rdy=000", bus.wr_en, bus.req_ready);
    end
    tick;
    tick;
    rst = 1'b0;
    set_req(1, 1'b0, 5'd2, 32'h101);
    set_req(2, 1'b0, 5'd3, 32'h102);
    #1;
    checks++;
    if (bus.req_ready !== 3'b001) begin
      errors++; $display("FAIL rst_req0_ready got %b exp 001", bus.req_ready);
    end
    tick;
    set_req(0, 1'b0, 5'd1, 32'h100);
    checks++;
    if (bus.wr_en !== 1'b1 || bus.grant_id !== 2'd0 || bus.wr_addr !== 5'd1) begin
      errors++;
      $display("FAIL rst_req0_wr got en=%b g=%0d a=%0d exp en=1 g=0 a=1",
               bus.wr_en, bus.grant_id, bus.wr_addr);
    end
  endtask

  task automatic test_single;
    do_reset;
    set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    checks++;
    if (bus.req_ready !== 3'b010) begin
      errors++; $display("FAIL single_ready got %b exp 010", bus.req_ready);
    end
    tick;
    set_req(1, 1'b0, 5'd5, 32'hDEADBEEF);
    checks++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.grant_id} !== {1'b1, 5'd5, 32'hDEADBEEF, 2'd1}) begin
      errors++;
      $display("FAIL single_wr got en=%b a=%0d d=%h g=%0d exp en=1 a=5 d=deadbeef g=1",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.grant_id);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rf[5] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_r5 got %h exp deadbeef", rf[5]);
    end
    tick;
    checks++;
    if (bus.wr_en !== 1'b0 || bus.wr_addr !== 5'd5) begin
      errors++; $display("FAIL single_idle got en=%b a=%0d exp en=0 a=5", bus.wr_en, bus.wr_addr);
    end
  endtask

  task automatic test_rotation;
    logic [N-1:0] exp_rdy;
    do_reset;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(10 + i), DW'(32'hA0 + i));
    for (int c = 0; c < 6; c++) begin
      #1;
      exp_rdy = 3'b001 << (c % N);
      checks++;
      if (bus.req_ready !== exp_rdy) begin
        errors++; $display("FAIL rot_ready c%0d got %b exp %b", c, bus.req_ready, exp_rdy);
      end
      tick;
      checks++;
      if (bus.wr_en !== 1'b1 || bus.grant_id !== IW'(c % N) || bus.wr_addr !== AW'(10 + c % N)) begin
        errors++;
        $display("FAIL rot_wr c%0d got en=%b g=%0d a=%0d exp en=1 g=%0d a=%0d",
                 c, bus.wr_en, bus.grant_id, bus.wr_addr, c % N, 10 + c % N);
      end
    end
    bus.req_valid = '0;
  endtask

  task automatic test_r0;
    do_reset;
    set_req(0, 1'b1, 5'd0, 32'h1234);
    #1;
    checks++;
    if (bus.req_ready !== 3'b001) begin
      errors++; $display("FAIL r0_ready got %b exp 001", bus.req_ready);
    end
    tick;
    checks++;
    if (bus.wr_en !== 1'b0) begin
      errors++; $display("FAIL r0_wr_en got %b exp 0", bus.wr_en);
    end
    set_req(1, 1'b1, 5'd6, 32'h66);
    #1;
    checks++;
    if (bus.req_ready !== 3'b010) begin
      errors++; $display("FAIL r0_ptr_adv got %b exp 010", bus.req_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rf[0] !== 32'h0) begin
      errors++; $display("FAIL r0_reg got %h exp 0", rf[0]);
    end
    tick;
    bus.req_valid = '0;
  endtask

  task automatic test_hold;
    do_reset;
    set_req(0, 1'b1, 5'd3, 32'h30);
    #1;
    tick;
    set_req(0, 1'b0, 5'd3, 32'h30);
    bus.hold = 1'b1;
    set_req(2, 1'b1, 5'd9, 32'h99);
    for (int h = 0; h < 3; h++) begin
      #1;
      checks++;
      if (bus.req_ready !== 3'b000) begin
        errors++; $display("FAIL hold_ready h%0d got %b exp 000", h, bus.req_ready);
      end
      if (h == 0) begin
        checks++;
        if (bus.wr_en !== 1'b1) begin
          errors++; $display("FAIL hold_drain got en=%b exp 1", bus.wr_en);
        end
      end
      tick;
      checks++;
      if (bus.wr_en !== 1'b0) begin
        errors++; $display("FAIL hold_wr_en h%0d got %b exp 0", h, bus.wr_en);
      end
    end
    bus.hold = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 3'b100) begin
      errors++; $display("FAIL hold_release got %b exp 100", bus.req_ready);
    end
    tick;
    set_req(2, 1'b0, 5'd9, 32'h99);
    checks++;
    if (bus.wr_en !== 1'b1 || bus.grant_id !== 2'd2 || bus.wr_addr !== 5'd9) begin
      errors++;
      $display("FAIL hold_req2_wr got en=%b g=%0d a=%0d exp en=1 g=2 a=9",
               bus.wr_en, bus.grant_id, bus.wr_addr);
    end
    set_req(0, 1'b1, 5'd4, 32'h40);
    #1;
    tick;
    set_req(0, 1'b0, 5'd4, 32'h40);
    bus.hold = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(20 + i), DW'(i));
    tick;
    tick;
    bus.hold = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 3'b010) begin
      errors++; $display("FAIL hold_ptr_frozen got %b exp 010", bus.req_ready);
    end
    tick;
    bus.req_valid = '0;
  endtask

  task automatic test_same_dest;
    do_reset;
    set_req(0, 1'b1, 5'd7, 32'd1);
    set_req(2, 1'b1, 5'd7, 32'd2);
    #1;
    checks++;
    if (bus.req_ready !== 3'b001) begin
      errors++; $display("FAIL same_ready0 got %b exp 001", bus.req_ready);
    end
    tick;
    set_req(0, 1'b0, 5'd7, 32'd1);
    #1;
    checks++;
    if (bus.req_ready !== 3'b100) begin
      errors++; $display("FAIL same_ready2 got %b exp 100", bus.req_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rf[7] !== 32'd1) begin
      errors++; $display("FAIL same_r7_first got %h exp 1", rf[7]);
    end
    tick;
    set_req(2, 1'b0, 5'd7, 32'd2);
    @(negedge clk);
    #1;
    checks++;
    if (rf[7] !== 32'd2) begin
      errors++; $display("FAIL same_r7_last got %h exp 2", rf[7]);
    end
    tick;
  endtask

  task automatic test_random;
    logic [N-1:0]  pv;
    logic [AW-1:0] pa [N];
    logic [DW-1:0] pd [N];
    logic [DW-1:0] m_regs [32];
    logic [N-1:0]  exp_rdy, seen_rdy;
    logic          m_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_ptr, m_gid, w, j;
    do_reset;
    pv = '0; m_en = 1'b0; m_addr = '0; m_data = '0; m_ptr = 0; m_gid = 0;
    for (int r = 0; r < 32; r++) m_regs[r] = '0;
    for (int i = 0; i < N; i++) begin pa[i] = '0; pd[i] = '0; end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 2) != 0) begin
          pv[i] = 1'b1;
          pa[i] = AW'($urandom_range(0, 31));
          pd[i] = $urandom;
        end
        set_req(i, pv[i], pa[i], pd[i]);
      end
      bus.hold = ($urandom_range(0, 5) == 0);
      #1;
      w = -1;
      if (!bus.hold) begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (w < 0 && pv[j]) w = j;
        end
      end
      exp_rdy = (w >= 0) ? (N'(1) << w) : '0;
      checks++;
      if (bus.req_ready !== exp_rdy) begin
        errors++; $display("FAIL rnd_ready c%0d got %b exp %b", c, bus.req_ready, exp_rdy);
      end
      seen_rdy = bus.req_ready;
      tick;
      if (w >= 0) begin
        m_en   = (pa[w] != '0);
        m_addr = pa[w];
        m_data = pd[w];
        m_gid  = w;
        m_ptr  = (w + 1) % N;
      end else begin
        m_en = 1'b0;
      end
      if (m_en) m_regs[m_addr] = m_data;
      pv = pv & ~seen_rdy;
      checks++;
      if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.grant_id} !== {m_en, m_addr, m_data, IW'(m_gid)}) begin
        errors++;
        $display("FAIL rnd_wr c%0d got en=%b a=%0d d=%h g=%0d exp en=%b a=%0d d=%h g=%0d",
                 c, bus.wr_en, bus.wr_addr, bus.wr_data, bus.grant_id, m_en, m_addr, m_data, m_gid);
      end
    end
    bus.req_valid = '0;
    bus.hold      = 1'b0;
    tick;
    tick;
    for (int r = 0; r < 32; r++) begin
      checks++;
      if (rf[r] !== m_regs[r]) begin
        errors++; $display("FAIL rnd_reg r%0d got %h exp %h", r, rf[r], m_regs[r]);
      end
    end
  endtask

  initial begin
    bus.hold      = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    test_reset;
    test_single;
    test_rotation;
    test_r0;
    test_hold;
    test_same_dest;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
